// File: rtl/biss_sniffer_crc_if.sv
`default_nettype none
// ============================================================================
// Module   : biss_sniffer_crc_if
// Purpose  : Position/status bus published by the BiSS-C frame sniffer.
//            The sniffer drives it through the master modport. Consumers
//            read it through the slave modport.
// Revision : 1.0 - initial release
// ============================================================================
interface biss_sniffer_crc_if #(
    parameter int POSN_W = 32
);
    logic [POSN_W-1:0] posn_o;        // last CRC-good position, zero-extended
    logic              posn_valid_o;  // one-cycle strobe on position update
    logic              error_o;       // inverted nE of last good frame
    logic              warning_o;     // inverted nW of last good frame
    logic [1:0]        health_o;      // 0 ok, 1 CRC bad, 2 timeout/abort, 3 none

    modport master (
        output posn_o,
        output posn_valid_o,
        output error_o,
        output warning_o,
        output health_o
    );

    modport slave (
        input posn_o,
        input posn_valid_o,
        input error_o,
        input warning_o,
        input health_o
    );
endinterface
`default_nettype wire

// File: rtl/biss_sniffer_crc.sv
`default_nettype none
// ============================================================================
// Module   : biss_sniffer_crc
// Purpose  : Passive BiSS-C frame monitor. Listens to MA and SLO without
//            driving them. Decodes a frame of runtime-selected position
//            width, checks the 6-bit CRC (x^6+x+1), and publishes only
//            CRC-good positions plus a per-frame health code.
// Revision : 1.0 - initial release
// ============================================================================
module biss_sniffer_crc #(
    parameter int POSN_W      = 32,
    parameter int TIMEOUT_CYC = 1250
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [7:0]                BITS,
    input  logic                      ssi_sck_i,
    input  logic                      ssi_dat_i,
    biss_sniffer_crc_if.master        posn_bus_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [7:0] c_POSN_W8 = 8'(POSN_W);
    localparam int         c_TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TO_W-1:0] c_TIMEOUT = c_TO_W'(TIMEOUT_CYC);

    localparam logic [1:0] c_HEALTH_OK      = 2'd0;
    localparam logic [1:0] c_HEALTH_CRC     = 2'd1;
    localparam logic [1:0] c_HEALTH_ABORT   = 2'd2;
    localparam logic [1:0] c_HEALTH_NOFRAME = 2'd3;

    // CRC polynomial x^6+x+1 without the implicit x^6 term
    localparam logic [5:0] c_CRC_TAPS = 6'b000011;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ACK       = 3'd1,
        S_CDS       = 3'd2,
        S_DATA      = 3'd3,
        S_STATUS    = 3'd4,
        S_CRC       = 3'd5,
        S_WAIT_IDLE = 3'd6
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic              sck_s1_q, sck_s2_q, sck_q;
    logic              dat_s1_q, dat_s2_q;
    logic              w_rise, w_fall, w_dat;

    logic [c_TO_W-1:0] idle_cnt_q;
    logic              w_timeout;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        bits_q;
    logic [7:0]        w_bits_clamp;

    logic              w_start;
    logic              w_shift_pos;
    logic              w_shift_st;
    logic              w_shift_crc;
    logic              w_done;
    logic              w_abort;

    logic [POSN_W-1:0] pos_sh_q;
    logic [1:0]        st_q;          // [1] = nE, [0] = nW
    logic [5:0]        crc_rx_q;      // received (inverted) CRC
    logic [5:0]        lfsr_q;
    logic [5:0]        w_lfsr_nx;
    logic              w_lfsr_fb;
    logic              pend_q;        // frame complete, result published next cycle
    logic              w_crc_pass;

    logic [POSN_W-1:0] posn_q;
    logic              valid_q;
    logic              err_q;
    logic              warn_q;
    logic [1:0]        health_q;

    // ------------------------------------------------------------------------
    // Input synchronisation and MA edge detection
    // ------------------------------------------------------------------------
    // Two-stage synchronisers for MA/SLO plus a delayed MA copy for edges.
    // A zero reset value means a line that is already low at reset release
    // never produces a spurious falling edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sck_s1_q <= 1'b0;
            sck_s2_q <= 1'b0;
            sck_q    <= 1'b0;
            dat_s1_q <= 1'b0;
            dat_s2_q <= 1'b0;
        end else begin
            sck_s1_q <= ssi_sck_i;
            sck_s2_q <= sck_s1_q;
            sck_q    <= sck_s2_q;
            dat_s1_q <= ssi_dat_i;
            dat_s2_q <= dat_s1_q;
        end
    end

    assign w_rise = sck_s2_q & ~sck_q;
    assign w_fall = ~sck_s2_q & sck_q;
    assign w_dat  = dat_s2_q;

    // ------------------------------------------------------------------------
    // MA-high cycle counter (frame end / abort detection)
    // ------------------------------------------------------------------------
    // Counts consecutive MA-high cycles, saturating at the timeout value.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            idle_cnt_q <= '0;
        end else if (!sck_s2_q) begin
            idle_cnt_q <= '0;
        end else if (idle_cnt_q != c_TIMEOUT) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end

    assign w_timeout = (idle_cnt_q == c_TIMEOUT);

    // Out-of-range widths fall back to the full position width
    assign w_bits_clamp = ((BITS == 8'd0) || (BITS > c_POSN_W8)) ? c_POSN_W8 : BITS;

    // ------------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------------
    // State and bit-counter registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and per-strobe datapath controls.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        w_start     = 1'b0;
        w_shift_pos = 1'b0;
        w_shift_st  = 1'b0;
        w_shift_crc = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A fall implies MA was high beforehand
                if (w_fall) begin
                    state_d = S_ACK;
                    cnt_d   = 8'd0;
                    w_start = 1'b1;
                end
            end

            S_ACK: begin
                if (w_timeout) begin
                    state_d = S_IDLE;
                    w_abort = 1'b1;
                end else if (w_rise && w_dat) begin
                    state_d = S_CDS;
                end
            end

            S_CDS: begin
                if (w_timeout) begin
                    state_d = S_IDLE;
                    w_abort = 1'b1;
                end else if (w_rise) begin
                    state_d = S_DATA;
                    cnt_d   = bits_q - 8'd1;
                end
            end

            S_DATA: begin
                if (w_timeout) begin
                    state_d = S_IDLE;
                    w_abort = 1'b1;
                end else if (w_rise) begin
                    w_shift_pos = 1'b1;
                    if (cnt_q == 8'd0) begin
                        state_d = S_STATUS;
                        cnt_d   = 8'd1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end

            S_STATUS: begin
                if (w_timeout) begin
                    state_d = S_IDLE;
                    w_abort = 1'b1;
                end else if (w_rise) begin
                    w_shift_st = 1'b1;
                    if (cnt_q == 8'd0) begin
                        state_d = S_CRC;
                        cnt_d   = 8'd5;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end

            S_CRC: begin
                if (w_timeout) begin
                    state_d = S_IDLE;
                    w_abort = 1'b1;
                end else if (w_rise) begin
                    w_shift_crc = 1'b1;
                    if (cnt_q == 8'd0) begin
                        state_d = S_WAIT_IDLE;
                        w_done  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end

            S_WAIT_IDLE: begin
                // A new MA low before the line settles is a frame overrun
                if (w_fall) begin
                    state_d = S_IDLE;
                    w_abort = 1'b1;
                end else if (w_timeout) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        if (state_d == S_IDLE) begin
            cnt_d = 8'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Serial CRC: x^6 + x + 1, seed 0, MSB first over data and status bits
    // ------------------------------------------------------------------------
    assign w_lfsr_fb = lfsr_q[5] ^ w_dat;
    assign w_lfsr_nx = {lfsr_q[4:0], 1'b0} ^ (w_lfsr_fb ? c_CRC_TAPS : 6'd0);

    // The slave transmits the CRC inverted
    assign w_crc_pass = (lfsr_q == ~crc_rx_q);

    // ------------------------------------------------------------------------
    // Frame datapath
    // ------------------------------------------------------------------------
    // Width latch, position/status/CRC shift registers and running LFSR.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bits_q   <= 8'd0;
            pos_sh_q <= '0;
            st_q     <= 2'b00;
            crc_rx_q <= 6'd0;
            lfsr_q   <= 6'd0;
            pend_q   <= 1'b0;
        end else begin
            pend_q <= w_done;
            if (w_start) begin
                bits_q   <= w_bits_clamp;
                pos_sh_q <= '0;
                st_q     <= 2'b00;
                crc_rx_q <= 6'd0;
                lfsr_q   <= 6'd0;
            end
            if (w_shift_pos) begin
                // Cleared at frame start, so bits above the width read 0
                pos_sh_q <= {pos_sh_q[POSN_W-2:0], w_dat};
                lfsr_q   <= w_lfsr_nx;
            end
            if (w_shift_st) begin
                st_q   <= {st_q[0], w_dat};
                lfsr_q <= w_lfsr_nx;
            end
            if (w_shift_crc) begin
                crc_rx_q <= {crc_rx_q[4:0], w_dat};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Published outputs
    // ------------------------------------------------------------------------
    // Result publication one cycle after the final CRC sample; aborts win.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            posn_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            warn_q   <= 1'b0;
            health_q <= c_HEALTH_NOFRAME;
        end else begin
            valid_q <= 1'b0;
            if (w_abort) begin
                health_q <= c_HEALTH_ABORT;
            end else if (pend_q) begin
                if (w_crc_pass) begin
                    posn_q   <= pos_sh_q;
                    err_q    <= ~st_q[1];
                    warn_q   <= ~st_q[0];
                    health_q <= c_HEALTH_OK;
                    valid_q  <= 1'b1;
                end else begin
                    health_q <= c_HEALTH_CRC;
                end
            end
        end
    end

    assign posn_bus_o.posn_o       = posn_q;
    assign posn_bus_o.posn_valid_o = valid_q;
    assign posn_bus_o.error_o      = err_q;
    assign posn_bus_o.warning_o    = warn_q;
    assign posn_bus_o.health_o     = health_q;

endmodule
`default_nettype wire
